apb_slave_regfile: RTL and testbench

- APB3 completer that sits directly downstream of apb_master: consumes psel/penable/paddr/pwrite/pwdata and returns pready/prdata/pslverr.
- Backed by a DEPTH-word register file.
- Wait states are programmable by parameter.
- Flags misaligned and out-of-range accesses with pslverr.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_slv_mem.sv | 47 ++++
 rtl/apb_slave_regfile.sv | 143 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and width helpers for the APB register-file completer.
package apb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

  // Word-index width; a single-word file still needs one bit of index.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Wait-counter width wide enough to hold WAIT_CYCLES itself.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_slv_mem.sv
// Register file: one byte-enabled write port, one asynchronous read port,
// every word cleared on reset.
module apb_slv_mem
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned IDX_W  = idx_width(DEPTH),
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Merge enabled write bytes into the addressed word.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_d[waddr][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer backed by a DEPTH-word register file with WAIT_CYCLES wait
// states per access. Misaligned and out-of-range accesses answer pslverr.
// Optional feature: define APB_SLV_PSTRB_EN to add the pstrb byte-strobe port;
// without it every write updates the full word.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  localparam int unsigned IDX_W  = idx_width(DEPTH);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CntInit = CNT_W'(WAIT_CYCLES);

  apb_slv_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic [ADDR_W-1:0] word_addr;
  logic              setup_err;
  logic [IDX_W-1:0]  setup_idx;
  logic [STRB_W-1:0] setup_strb;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign word_addr = paddr >> 2;
  assign setup_err = (paddr[1:0] != 2'b00) | (word_addr >= ADDR_W'(DEPTH));
  assign setup_idx = paddr[2 +: IDX_W];
`ifdef APB_SLV_PSTRB_EN
  assign setup_strb = pstrb;
`else
  assign setup_strb = {STRB_W{1'b1}};
`endif

  apb_slv_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .raddr (setup_idx),
    .rdata (mem_rdata)
  );

  // Next state: latch the request at setup, count wait states, commit at completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    prdata_d = prdata_q;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // psel with penable already high is a protocol violation and is ignored.
        if (psel && !penable) begin
          state_d  = ACCESS;
          cnt_d    = CntInit;
          idx_d    = setup_idx;
          write_d  = pwrite;
          err_d    = setup_err;
          wdata_d  = pwdata;
          strb_d   = setup_strb;
          prdata_d = (pwrite || setup_err) ? '0 : mem_rdata;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            mem_we  = write_q & ~err_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      prdata_q <= prdata_d;
    end
  end

  // Response outputs, purely from registered state.
  always_comb begin
    pready  = (state_q == ACCESS) && (cnt_q == '0);
    pslverr = pready && err_q;
    prdata  = prdata_q;
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized self-checking bench: two completers (WAIT_CYCLES=1 and 0) are
// driven in turn and compared against a word-array model of the register file.
module tb_apb_slave_regfile;

`ifdef APB_SLV_PSTRB_EN
  localparam bit HasStrb = 1'b1;
`else
  localparam bit HasStrb = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        psel    [2];
  logic        penable [2];
  logic [31:0] paddr   [2];
  logic        pwrite  [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic        pready  [2];
  logic [31:0] prdata  [2];
  logic        pslverr [2];

  int          waits [2] = '{1, 0};
  logic [31:0] mdl [2][16];
  int          n_total = 0;
  int          n_bad   = 0;

  apb_slave_regfile #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH       (16),
    .WAIT_CYCLES (1)
  ) u_dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .psel    (psel[0]),
    .penable (penable[0]),
    .paddr   (paddr[0]),
    .pwrite  (pwrite[0]),
    .pwdata  (pwdata[0]),
`ifdef APB_SLV_PSTRB_EN
    .pstrb   (pstrb[0]),
`endif
    .pready  (pready[0]),
    .prdata  (prdata[0]),
    .pslverr (pslverr[0])
  );

  apb_slave_regfile #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH       (16),
    .WAIT_CYCLES (0)
  ) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .psel    (psel[1]),
    .penable (penable[1]),
    .paddr   (paddr[1]),
    .pwrite  (pwrite[1]),
    .pwdata  (pwdata[1]),
`ifdef APB_SLV_PSTRB_EN
    .pstrb   (pstrb[1]),
`endif
    .pready  (pready[1]),
    .prdata  (prdata[1]),
    .pslverr (pslverr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) mdl[d][i] = 32'h0;
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
    end
  endtask

  // One APB transfer; returns data/error seen at pready and access-phase cycles.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err, output int cyc);
    int n;
    @(negedge clk);
    psel[1-d]    = 1'b0;
    penable[1-d] = 1'b0;
    psel[d]      = 1'b1;
    penable[d]   = 1'b0;
    paddr[d]     = addr;
    pwrite[d]    = wr;
    pwdata[d]    = wdata;
    pstrb[d]     = strb;
    @(negedge clk);
    penable[d] = 1'b1;
    // The completer must use its latched copy, so disturb the bus.
    paddr[d]   = $urandom;
    pwdata[d]  = $urandom;
    pwrite[d]  = ~wr;
    pstrb[d]   = 4'($urandom);
    n = 1;
    #1;
    while (!pready[d] && n < 20) begin
      check_eq("pslverr_while_waiting", {31'b0, pslverr[d]}, 32'h0);
      @(negedge clk);
      n++;
    end
    if (!pready[d]) check_eq("pready_timeout", 32'h0, 32'h1);
    cyc   = n;
    rdata = prdata[d];
    err   = pslverr[d];
    @(posedge clk);
  endtask

  // Transfer plus comparison against the model, then model update.
  task automatic xfer_check(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb, input string tag);
    logic [31:0] rd;
    logic        er;
    int          cyc;
    logic        err_e;
    logic [31:0] exp_rd;
    logic [3:0]  s;
    s      = HasStrb ? strb : 4'hF;
    err_e  = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd16);
    exp_rd = (wr || err_e) ? 32'h0 : mdl[d][addr[5:2]];
    apb_xfer(d, wr, addr, wdata, strb, rd, er, cyc);
    check_eq({tag, ".cycles"}, cyc, waits[d] + 1);
    check_eq({tag, ".pslverr"}, {31'b0, er}, {31'b0, err_e});
    check_eq({tag, ".prdata"}, rd, exp_rd);
    if (wr && !err_e) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[d][addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    int          d;
    int          sel;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; paddr[i] = '0;
      pwrite[i] = 1'b0; pwdata[i] = '0; pstrb[i] = 4'hF;
    end
    clear_model();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq("reset.pready", {31'b0, pready[i]}, 32'h0);
      check_eq("reset.pslverr", {31'b0, pslverr[i]}, 32'h0);
      check_eq("reset.prdata", prdata[i], 32'h0);
    end
    rst_n = 1'b1;

    // Basic write/readback with one wait state.
    xfer_check(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, "wr08");
    xfer_check(0, 1'b0, 32'h08, 32'h0, 4'hF, "rd08");

    // Error responses; the misaligned write must not touch memory.
    xfer_check(0, 1'b0, 32'h40, 32'h0, 4'hF, "rd40_oor");
    xfer_check(0, 1'b1, 32'h41, 32'h11223344, 4'hF, "wr41_misal");
    xfer_check(0, 1'b0, 32'h40, 32'h0, 4'hF, "rd40_again");
    xfer_check(0, 1'b0, 32'h00, 32'h0, 4'hF, "rd00_unchanged");

    // Zero-wait back-to-back writes, then readback.
    xfer_check(1, 1'b1, 32'h00, 32'hCAFE0000, 4'hF, "b2b_wr00");
    xfer_check(1, 1'b1, 32'h04, 32'h0000F00D, 4'hF, "b2b_wr04");
    xfer_check(1, 1'b0, 32'h00, 32'h0, 4'hF, "b2b_rd00");
    xfer_check(1, 1'b0, 32'h04, 32'h0, 4'hF, "b2b_rd04");
    bus_idle();

    // Protocol violation in IDLE is ignored.
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 32'h08; pwrite[0] = 1'b1;
    pwdata[0] = 32'h0BAD0BAD;
    @(negedge clk);
    check_eq("violation.pready", {31'b0, pready[0]}, 32'h0);
    bus_idle();
    xfer_check(0, 1'b0, 32'h08, 32'h0, 4'hF, "violation.rd08");

    // Abort during the wait state.
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 32'h0C; pwrite[0] = 1'b1;
    pwdata[0] = 32'h12345678;
    @(negedge clk);
    psel[0] = 1'b0;
    #1 check_eq("abort.pready_wait", {31'b0, pready[0]}, 32'h0);
    @(negedge clk);
    check_eq("abort.pready_after", {31'b0, pready[0]}, 32'h0);
    xfer_check(0, 1'b0, 32'h0C, 32'h0, 4'hF, "abort.rd0c");

    // Asynchronous reset while a read is completing.
    xfer_check(0, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, "wr10");
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 32'h10; pwrite[0] = 1'b0;
    @(negedge clk);
    penable[0] = 1'b1;
    @(negedge clk);
    check_eq("midrst.pready_before", {31'b0, pready[0]}, 32'h1);
    check_eq("midrst.prdata_before", prdata[0], 32'hA5A5A5A5);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst.pready", {31'b0, pready[0]}, 32'h0);
    check_eq("midrst.pslverr", {31'b0, pslverr[0]}, 32'h0);
    check_eq("midrst.prdata", prdata[0], 32'h0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    xfer_check(0, 1'b0, 32'h10, 32'h0, 4'hF, "midrst.rd10");
    xfer_check(1, 1'b0, 32'h04, 32'h0, 4'hF, "midrst.rd04_dut1");

    if (HasStrb) begin
      xfer_check(0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'hF, "strb.wr_full");
      xfer_check(0, 1'b1, 32'h14, 32'h00000000, 4'b0101, "strb.wr_part");
      xfer_check(0, 1'b0, 32'h14, 32'h0, 4'hF, "strb.rd");
      check_eq("strb.value", mdl[0][5], 32'hFF00FF00);
      xfer_check(0, 1'b1, 32'h14, 32'h12345678, 4'b0000, "strb.wr_none");
      xfer_check(0, 1'b0, 32'h14, 32'h0, 4'b0000, "strb.rd2");
    end

    // Randomized traffic, sometimes back-to-back, sometimes with idle gaps.
    for (int i = 0; i < 300; i++) begin
      d   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      else if (sel == 7) a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      else if (sel == 8) a = {24'b0, 6'($urandom_range(16, 63)), 2'b00};
      else               a = $urandom;
      xfer_check(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), "rand");
      if ($urandom_range(0, 3) == 0) bus_idle();
    end

    // Full readback of both register files.
    for (int dd = 0; dd < 2; dd++) begin
      for (int w = 0; w < 16; w++) begin
        xfer_check(dd, 1'b0, 32'(w * 4), 32'h0, 4'hF, "final_rd");
      end
    end
    bus_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
